// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// the controller state encoding, the slice width and a width helper.
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Request/result bundle for cla_seq_adder. The ovf signal only exists
// when CLA_SEQ_OVF_EN is defined.
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/cla_seq_adder_cla_4bit.sv
// Combinational 4-bit carry-lookahead slice: every carry is computed
// directly from generate/propagate terms and the slice carry-in.
module cla_4bit
    import cla_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W:0]   c;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLE_W; gi++) begin : g_pg
            assign p[gi] = a[gi] ^ b[gi];
            assign g[gi] = a[gi] & b[gi];
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract unit: one cla_4bit slice is reused WIDTH/4
// times, LSB nibble first, with the running carry held in a register.
// Optional feature macro: CLA_SEQ_OVF_EN adds a signed-overflow output.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_adder_if.slave bus
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = clog2(NIB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 2 * NIBBLE_W)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t state_reg;
    state_t state_next;
    logic   in_ready_reg;

    logic [WIDTH-1:0]          a_reg;
    logic [WIDTH-1:0]          b_reg;
    logic                      carry_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [WIDTH-NIBBLE_W-1:0] sum_sh_reg;
    logic [WIDTH-NIBBLE_W-1:0] sum_sh_next;
    logic [WIDTH-1:0]          sum_reg;
    logic                      cout_reg;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                accept;
    logic                last_step;

    assign accept    = (state_reg == IDLE) && bus.in_valid && in_ready_reg;
    assign last_step = (state_reg == RUN) && (cnt_reg == LAST);

    cla_4bit u_slice (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // New slice nibble enters at the top; older nibbles move one slot down.
    genvar gi;
    generate
        for (gi = 0; gi < NIB - 1; gi++) begin : g_sum_shift
            if (gi == NIB - 2) begin : g_top
                assign sum_sh_next[gi*NIBBLE_W +: NIBBLE_W] = slice_s;
            end else begin : g_mid
                assign sum_sh_next[gi*NIBBLE_W +: NIBBLE_W] =
                    sum_sh_reg[(gi+1)*NIBBLE_W +: NIBBLE_W];
            end
        end
    endgenerate

    // Next-state logic: accept from IDLE, count nibbles in RUN, wait for consumer in DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (bus.in_valid && in_ready_reg) state_next = RUN;
            RUN:  if (cnt_reg == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; in_ready is registered and stays low the cycle reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next == IDLE);
        end
    end

    // Operand shift registers, running carry and nibble counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_sh_reg <= '0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg      <= {{NIBBLE_W{1'b0}}, a_reg[WIDTH-1:NIBBLE_W]};
            b_reg      <= {{NIBBLE_W{1'b0}}, b_reg[WIDTH-1:NIBBLE_W]};
            carry_reg  <= slice_cout;
            cnt_reg    <= cnt_reg + 1'b1;
            sum_sh_reg <= sum_sh_next;
        end
    end

    // Result registers load only on the final step so they hold steady otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (last_step) begin
            sum_reg  <= {slice_s, sum_sh_reg};
            cout_reg <= slice_cout;
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic ovf_reg;

    // Signed overflow from the top nibble: same input signs, different result sign.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_step) begin
            ovf_reg <= (a_reg[NIBBLE_W-1] == b_reg[NIBBLE_W-1]) &&
                       (slice_s[NIBBLE_W-1] != a_reg[NIBBLE_W-1]);
        end
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder at WIDTH=16 (four nibble steps).
module tb_cla_seq_adder;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    cla_seq_adder_if #(.WIDTH(W)) bus ();

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; return the result seen in the first out_valid cycle.
    // lat counts cycles: the cycle right after the accept edge is 1.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input logic rdy_after,
                          output logic [W-1:0] rs, output logic rc, output logic ro,
                          output int lat);
        int n;
        bus.a        = ta;
        bus.b        = tb;
        bus.cin      = tcin;
        bus.sub      = tsub;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = rdy_after;
        lat = 1;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        rs = bus.sum;
        rc = bus.cout;
`ifdef CLA_SEQ_OVF_EN
        ro = bus.ovf;
`else
        ro = 1'b0;
`endif
        $display("op a=%04h b=%04h cin=%0b sub=%0b -> sum=%04h cout=%0b ovf=%0b lat=%0d",
                 ta, tb, tcin, tsub, rs, rc, ro, lat);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        compared++;
        if (bus.sum !== 16'h0000) begin mismatched++; $display("FAIL reset_sum: got %04h expected 0000", bus.sum); end
        compared++;
        if (bus.cout !== 1'b0) begin mismatched++; $display("FAIL reset_cout: got %0b expected 0", bus.cout); end
`ifdef CLA_SEQ_OVF_EN
        compared++;
        if (bus.ovf !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %0b expected 0", bus.ovf); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL release_in_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h5555) begin mismatched++; $display("FAIL add_basic_sum: got %04h expected 5555", s); end
        compared++;
        if (c !== 1'b0) begin mismatched++; $display("FAIL add_basic_cout: got %0b expected 0", c); end
        compared++;
        if (lat !== 5) begin mismatched++; $display("FAIL add_basic_latency: got %0d expected 5", lat); end

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h0000) begin mismatched++; $display("FAIL add_ripple_sum: got %04h expected 0000", s); end
        compared++;
        if (c !== 1'b1) begin mismatched++; $display("FAIL add_ripple_cout: got %0b expected 1", c); end

        run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h0100) begin mismatched++; $display("FAIL add_cin_sum: got %04h expected 0100", s); end
        compared++;
        if (c !== 1'b0) begin mismatched++; $display("FAIL add_cin_cout: got %0b expected 0", c); end
    endtask

    task automatic test_sub();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        // cin is driven high to show it has no effect in subtract mode.
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'hFFFE) begin mismatched++; $display("FAIL sub_borrow_sum: got %04h expected fffe", s); end
        compared++;
        if (c !== 1'b0) begin mismatched++; $display("FAIL sub_borrow_cout: got %0b expected 0", c); end
`ifdef CLA_SEQ_OVF_EN
        compared++;
        if (o !== 1'b0) begin mismatched++; $display("FAIL sub_borrow_ovf: got %0b expected 0", o); end
`endif
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h0002) begin mismatched++; $display("FAIL sub_pos_sum: got %04h expected 0002", s); end
        compared++;
        if (c !== 1'b1) begin mismatched++; $display("FAIL sub_pos_cout: got %0b expected 1", c); end
    endtask

    task automatic test_ovf();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h8000) begin mismatched++; $display("FAIL ovf_add_sum: got %04h expected 8000", s); end
        compared++;
        if (c !== 1'b0) begin mismatched++; $display("FAIL ovf_add_cout: got %0b expected 0", c); end
`ifdef CLA_SEQ_OVF_EN
        compared++;
        if (o !== 1'b1) begin mismatched++; $display("FAIL ovf_add_flag: got %0b expected 1", o); end
`endif
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h7FFF) begin mismatched++; $display("FAIL ovf_sub_sum: got %04h expected 7fff", s); end
        compared++;
        if (c !== 1'b1) begin mismatched++; $display("FAIL ovf_sub_cout: got %0b expected 1", c); end
`ifdef CLA_SEQ_OVF_EN
        compared++;
        if (o !== 1'b1) begin mismatched++; $display("FAIL ovf_sub_flag: got %0b expected 1", o); end
`endif
    endtask

    task automatic test_hold();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, s, c, o, lat);
        compared++;
        if (s !== 16'h3333) begin mismatched++; $display("FAIL hold_first_sum: got %04h expected 3333", s); end
        bus.a        = 16'hAAAA;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            compared++;
            if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL hold_out_valid[%0d]: got %0b expected 1", i, bus.out_valid); end
            compared++;
            if (bus.sum !== 16'h3333) begin mismatched++; $display("FAIL hold_sum[%0d]: got %04h expected 3333", i, bus.sum); end
            compared++;
            if (bus.cout !== 1'b0) begin mismatched++; $display("FAIL hold_cout[%0d]: got %0b expected 0", i, bus.cout); end
            compared++;
            if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL hold_in_ready[%0d]: got %0b expected 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL hold_release_out_valid: got %0b expected 0", bus.out_valid); end
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL hold_release_in_ready: got %0b expected 1", bus.in_ready); end
        run_op(16'hAAAA, 16'h1111, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'hBBBB) begin mismatched++; $display("FAIL hold_second_sum: got %04h expected bbbb", s); end
        compared++;
        if (lat !== 5) begin mismatched++; $display("FAIL hold_second_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] s;
        logic c, o;
        int lat;
        int n;
        bus.a        = 16'h1111;
        bus.b        = 16'h1111;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;           // accept edge; now in RUN cycle 1
        bus.in_valid = 1'b0;
        @(posedge clk); #1;           // RUN cycle 2
        rst_n = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL run_reset_out_valid: got %0b expected 0", bus.out_valid); end
        compared++;
        if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL run_reset_in_ready: got %0b expected 0", bus.in_ready); end
        compared++;
        if (bus.sum !== 16'h0000) begin mismatched++; $display("FAIL run_reset_sum: got %04h expected 0000", bus.sum); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL run_reset_release_ready: got %0b expected 1", bus.in_ready); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, s, c, o, lat);
        compared++;
        if (s !== 16'h0002) begin mismatched++; $display("FAIL run_reset_next_sum: got %04h expected 0002", s); end
        compared++;
        if (lat !== 5) begin mismatched++; $display("FAIL run_reset_next_latency: got %0d expected 5", lat); end

        // Reset while a result is waiting in DONE.
        run_op(16'hF001, 16'h1001, 1'b0, 1'b0, 1'b0, s, c, o, lat);
        compared++;
        if (c !== 1'b1) begin mismatched++; $display("FAIL done_pre_reset_cout: got %0b expected 1", c); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL done_reset_out_valid: got %0b expected 0", bus.out_valid); end
        compared++;
        if (bus.sum !== 16'h0000) begin mismatched++; $display("FAIL done_reset_sum: got %04h expected 0000", bus.sum); end
        compared++;
        if (bus.cout !== 1'b0) begin mismatched++; $display("FAIL done_reset_cout: got %0b expected 0", bus.cout); end
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL done_reset_release_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic         pr, pv;
        int           edge_n, acc_n, res_n;
        int           acc_edge [2];
        logic [W-1:0] rsum [2];
        logic         rc [2];
        edge_n = 0;
        acc_n  = 0;
        res_n  = 0;
        acc_edge[0] = 0;
        acc_edge[1] = 0;
        bus.a         = 16'h0F0F;
        bus.b         = 16'h00F1;
        bus.cin       = 1'b1;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (res_n < 2 && edge_n < 40) begin
            pr = bus.in_ready;
            pv = bus.in_valid;
            @(posedge clk); #1;
            edge_n++;
            if (pr && pv && acc_n < 2) begin
                acc_edge[acc_n] = edge_n;
                acc_n++;
                if (acc_n == 1) begin
                    bus.a   = 16'h1000;
                    bus.b   = 16'h0001;
                    bus.cin = 1'b0;
                    bus.sub = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                rsum[res_n] = bus.sum;
                rc[res_n]   = bus.cout;
                $display("b2b result %0d: sum=%04h cout=%0b at edge %0d", res_n, bus.sum, bus.cout, edge_n);
                res_n++;
            end
        end
        bus.in_valid = 1'b0;
        compared++;
        if (res_n !== 2) begin mismatched++; $display("FAIL b2b_result_count: got %0d expected 2", res_n); end
        compared++;
        if (acc_n !== 2) begin mismatched++; $display("FAIL b2b_accept_count: got %0d expected 2", acc_n); end
        compared++;
        if (acc_edge[1] - acc_edge[0] !== 6) begin mismatched++; $display("FAIL b2b_accept_spacing: got %0d expected 6", acc_edge[1] - acc_edge[0]); end
        compared++;
        if (rsum[0] !== 16'h1001) begin mismatched++; $display("FAIL b2b_sum0: got %04h expected 1001", rsum[0]); end
        compared++;
        if (rc[0] !== 1'b0) begin mismatched++; $display("FAIL b2b_cout0: got %0b expected 0", rc[0]); end
        compared++;
        if (rsum[1] !== 16'h0FFF) begin mismatched++; $display("FAIL b2b_sum1: got %04h expected 0fff", rsum[1]); end
        compared++;
        if (rc[1] !== 1'b1) begin mismatched++; $display("FAIL b2b_cout1: got %0b expected 1", rc[1]); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_hold();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
